// File: rtl/can_tx_mailbox_arb.sv
// Transmit mailbox arbiter: latches mailbox requests, picks the lowest CAN
// arbitration key and sequences the shared frame engine through start, retry and abort.
module can_tx_mailbox_arb #(
    parameter int NUM_MB = 4,
    parameter int IDX_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_MB-1:0]    mb_req_i,
    input  logic [NUM_MB-1:0]    mb_abort_i,
    input  logic [NUM_MB*29-1:0] mb_id_i,
    input  logic [NUM_MB-1:0]    mb_ext_i,
    input  logic                 sso_i,
    input  logic                 bus_idle_i,
    input  logic                 tx_done_i,
    input  logic                 tx_arb_lost_i,
    input  logic                 tx_err_i,
    output logic                 tx_start_o,
    output logic [IDX_W-1:0]     tx_sel_o,
    output logic [28:0]          tx_id_o,
    output logic                 tx_ext_o,
    output logic [NUM_MB-1:0]    mb_pending_o,
    output logic [NUM_MB-1:0]    mb_done_o,
    output logic [NUM_MB-1:0]    mb_aborted_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;

    state_t             state_q, state_d;
    logic [NUM_MB-1:0]  pend_q, pend_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [28:0]        id_q, id_d;
    logic               ext_q, ext_d;
    logic               start_q, start_d;
    logic [NUM_MB-1:0]  done_q, done_d;
    logic [NUM_MB-1:0]  abrt_q, abrt_d;
    logic               abortLat_q, abortLat_d;

    logic [31:0]        key [NUM_MB];
    logic [NUM_MB-1:0]  avail;
    logic               winValid;
    logic [IDX_W-1:0]   winIdx;
    logic [28:0]        winId;
    logic               winExt;
    logic [31:0]        winKey;

    // A mailbox being aborted this cycle must not enter arbitration.
    always_comb begin
        avail    = pend_q & ~mb_abort_i;
        winValid = 1'b0;
        winIdx   = '0;
        winId    = '0;
        winExt   = 1'b0;
        winKey   = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            key[i] = mb_ext_i[i] ? {mb_id_i[29*i+18 +: 11], 1'b1, mb_id_i[29*i +: 18], 2'b00}
                                 : {mb_id_i[29*i+18 +: 11], 1'b0, 18'h0, 2'b00};
            if (avail[i] && (!winValid || key[i] < winKey)) begin
                winValid = 1'b1;
                winIdx   = IDX_W'(i);
                winId    = mb_id_i[29*i +: 29];
                winExt   = mb_ext_i[i];
                winKey   = key[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        sel_d      = sel_q;
        id_d       = id_q;
        ext_d      = ext_q;
        start_d    = 1'b0;
        done_d     = '0;
        abrt_d     = '0;
        abortLat_d = abortLat_q;

        // The in-flight mailbox defers its abort to frame end; all others drop at once.
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_abort_i[i]) begin
                if (pend_q[i] && !(state_q == WAIT && sel_q == IDX_W'(i))) begin
                    pend_d[i] = 1'b0;
                    abrt_d[i] = 1'b1;
                end
            end else if (mb_req_i[i]) begin
                pend_d[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                abortLat_d = 1'b0;
                if (winValid) begin
                    state_d = ARB;
                    sel_d   = winIdx;
                    id_d    = winId;
                    ext_d   = winExt;
                end
            end
            ARB: begin
                if (mb_abort_i[sel_q]) begin
                    state_d = IDLE;
                end else if (bus_idle_i) begin
                    state_d = WAIT;
                    start_d = 1'b1;
                end
            end
            WAIT: begin
                if (mb_abort_i[sel_q]) abortLat_d = 1'b1;
                if (tx_done_i) begin
                    pend_d[sel_q] = 1'b0;
                    done_d[sel_q] = 1'b1;
                    state_d       = IDLE;
                end else if (tx_err_i || tx_arb_lost_i) begin
                    if (sso_i || abortLat_q || mb_abort_i[sel_q]) begin
                        pend_d[sel_q] = 1'b0;
                        abrt_d[sel_q] = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            sel_q      <= '0;
            id_q       <= '0;
            ext_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= '0;
            abrt_q     <= '0;
            abortLat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            id_q       <= id_d;
            ext_q      <= ext_d;
            start_q    <= start_d;
            done_q     <= done_d;
            abrt_q     <= abrt_d;
            abortLat_q <= abortLat_d;
        end
    end

    assign tx_start_o   = start_q;
    assign tx_sel_o     = sel_q;
    assign tx_id_o      = id_q;
    assign tx_ext_o     = ext_q;
    assign mb_pending_o = pend_q;
    assign mb_done_o    = done_q;
    assign mb_aborted_o = abrt_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_can_tx_mailbox_arb.sv
// Scoreboard bench for can_tx_mailbox_arb: a transaction-level reference model
// predicts every start/done/aborted event, a monitor compares what the DUT presents.
module tb_can_tx_mailbox_arb;

    localparam int NMB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NMB-1:0]  mb_req_i, mb_abort_i, mb_ext_i;
    logic [NMB*29-1:0] mb_id_i;
    logic            sso_i, bus_idle_i, tx_done_i, tx_arb_lost_i, tx_err_i;
    logic            tx_start_o, tx_ext_o, busy_o;
    logic [1:0]      tx_sel_o;
    logic [28:0]     tx_id_o;
    logic [NMB-1:0]  mb_pending_o, mb_done_o, mb_aborted_o;

    can_tx_mailbox_arb #(.NUM_MB(NMB), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mb_req_i(mb_req_i), .mb_abort_i(mb_abort_i),
        .mb_id_i(mb_id_i), .mb_ext_i(mb_ext_i), .sso_i(sso_i), .bus_idle_i(bus_idle_i),
        .tx_done_i(tx_done_i), .tx_arb_lost_i(tx_arb_lost_i), .tx_err_i(tx_err_i),
        .tx_start_o(tx_start_o), .tx_sel_o(tx_sel_o), .tx_id_o(tx_id_o), .tx_ext_o(tx_ext_o),
        .mb_pending_o(mb_pending_o), .mb_done_o(mb_done_o), .mb_aborted_o(mb_aborted_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic           start;
        logic [1:0]     sel;
        logic [28:0]    id;
        logic           ext;
        logic [NMB-1:0] done;
        logic [NMB-1:0] abrt;
        logic [NMB-1:0] pend;
        logic           busy;
    } ev_t;

    ev_t expQ[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;

    // Reference model: phase 0 = nothing selected, 1 = winner chosen, 2 = frame on the bus.
    int             mPhase = 0;
    int             mSel = 0;
    logic [28:0]    mId = '0;
    logic           mExt = 1'b0;
    logic           mLatched = 1'b0;
    logic [NMB-1:0] mPend = '0;

    function automatic longint priorityOf(int mb);
        longint baseId = longint'(mb_id_i[29*mb+18 +: 11]);
        if (mb_ext_i[mb])
            return baseId * 2097152 + 1048576 + longint'(mb_id_i[29*mb +: 18]) * 4;
        return baseId * 2097152;
    endfunction

    always @(posedge clk) begin
        ev_t e;
        logic [NMB-1:0] newPend, dn, ab;
        logic st, abortSel;
        int best;
        cyc++;
        if (!rst_n) begin
            mPhase = 0; mSel = 0; mId = '0; mExt = 1'b0; mLatched = 1'b0; mPend = '0;
        end else begin
            newPend = mPend; dn = '0; ab = '0; st = 1'b0;
            for (int i = 0; i < NMB; i++) begin
                if (mb_abort_i[i]) begin
                    if (mPend[i] && !(mPhase == 2 && mSel == i)) begin
                        newPend[i] = 1'b0;
                        ab[i] = 1'b1;
                    end
                end else if (mb_req_i[i]) begin
                    newPend[i] = 1'b1;
                end
            end
            abortSel = mb_abort_i[mSel];
            if (mPhase == 0) begin
                mLatched = 1'b0;
                best = -1;
                for (int i = 0; i < NMB; i++)
                    if (mPend[i] && !mb_abort_i[i])
                        if (best < 0 || priorityOf(i) < priorityOf(best)) best = i;
                if (best >= 0) begin
                    mSel = best; mId = mb_id_i[29*best +: 29]; mExt = mb_ext_i[best]; mPhase = 1;
                end
            end else if (mPhase == 1) begin
                if (abortSel) mPhase = 0;
                else if (bus_idle_i) begin mPhase = 2; st = 1'b1; end
            end else begin
                if (tx_done_i) begin
                    newPend[mSel] = 1'b0; dn[mSel] = 1'b1; mPhase = 0;
                end else if (tx_err_i || tx_arb_lost_i) begin
                    if (sso_i || mLatched || abortSel) begin
                        newPend[mSel] = 1'b0; ab[mSel] = 1'b1;
                    end
                    mPhase = 0;
                end
                if (abortSel) mLatched = 1'b1;
            end
            mPend = newPend;
            if (st || dn != 0 || ab != 0) begin
                e.cyc = cyc; e.start = st; e.sel = 2'(mSel); e.id = mId; e.ext = mExt;
                e.done = dn; e.abrt = ab; e.pend = mPend; e.busy = (mPhase != 0);
                expQ.push_back(e);
            end
        end
    end

    // Monitor: compares whenever the DUT shows an event or one is due this cycle.
    always @(negedge clk) begin
        ev_t e;
        logic gotEv;
        gotEv = tx_start_o || (mb_done_o != 0) || (mb_aborted_o != 0);
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            compared++; mismatched++;
            $display("[TB] FAIL missingEvent due cyc=%0d now=%0d start=%b done=%b abrt=%b",
                     e.cyc, cyc, e.start, e.done, e.abrt);
        end
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            e = expQ.pop_front();
            compared++;
            if (tx_start_o !== e.start || tx_sel_o !== e.sel || tx_id_o !== e.id ||
                tx_ext_o !== e.ext || mb_done_o !== e.done || mb_aborted_o !== e.abrt ||
                mb_pending_o !== e.pend || busy_o !== e.busy) begin
                mismatched++;
                $display("[TB] FAIL event cyc=%0d got start=%b sel=%0d id=%h ext=%b done=%b abrt=%b pend=%b busy=%b want start=%b sel=%0d id=%h ext=%b done=%b abrt=%b pend=%b busy=%b",
                         cyc, tx_start_o, tx_sel_o, tx_id_o, tx_ext_o, mb_done_o, mb_aborted_o,
                         mb_pending_o, busy_o, e.start, e.sel, e.id, e.ext, e.done, e.abrt,
                         e.pend, e.busy);
            end
        end else if (gotEv) begin
            compared++; mismatched++;
            $display("[TB] FAIL unexpectedEvent cyc=%0d got start=%b done=%b abrt=%b want none",
                     cyc, tx_start_o, mb_done_o, mb_aborted_o);
        end
    end

    task automatic checkOutput(input string name);
        logic [63:0] got;
        @(negedge clk);
        got = {tx_start_o, tx_sel_o, tx_id_o, tx_ext_o, mb_pending_o, mb_done_o, mb_aborted_o, busy_o};
        compared++;
        if (got !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL %s got outputs=%h want 0", name, got);
        end
    endtask

    task automatic setId(input int mb, input logic [28:0] id, input logic ext);
        mb_id_i[29*mb +: 29] = id;
        mb_ext_i[mb] = ext;
    endtask

    // One cycle of pulses, then idleCycles quiet cycles.
    task automatic applyStimulus(input logic [NMB-1:0] req, input logic [NMB-1:0] abrt,
                                 input logic done, input logic err, input logic lost,
                                 input int idleCycles);
        mb_req_i = req; mb_abort_i = abrt;
        tx_done_i = done; tx_err_i = err; tx_arb_lost_i = lost;
        @(negedge clk);
        mb_req_i = '0; mb_abort_i = '0;
        tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0;
        repeat (idleCycles) @(negedge clk);
    endtask

    task automatic doReset(input string name);
        rst_n = 1'b0;
        @(negedge clk);
        mb_req_i = '0; mb_abort_i = '0;
        tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0;
        checkOutput(name);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [10:0] bases [3];
        bases[0] = 11'h0FF; bases[1] = 11'h100; bases[2] = 11'h0FF;
        rst_n = 1'b0;
        mb_req_i = '0; mb_abort_i = '0; mb_id_i = '0; mb_ext_i = '0;
        sso_i = 1'b0; bus_idle_i = 1'b1;
        tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0;
        @(negedge clk);
        checkOutput("resetState");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed: single request");
        setId(2, 29'h0123_0000, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 0, 0, 0, 5);
        applyStimulus(4'b0000, 4'b0000, 1, 0, 0, 3);

        $display("[TB] directed: priority order");
        setId(0, {11'h100, 18'h0}, 1'b0);
        setId(1, {11'h0FF, 18'h0}, 1'b0);
        setId(3, {11'h0FF, 18'h00001}, 1'b1);
        applyStimulus(4'b1011, 4'b0000, 0, 0, 0, 4);
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1, 0, 0, 4);

        $display("[TB] directed: arbitration loss");
        applyStimulus(4'b0001, 4'b0000, 0, 0, 0, 4);
        applyStimulus(4'b0010, 4'b0000, 0, 0, 0, 1);
        applyStimulus(4'b0000, 4'b0000, 0, 0, 1, 4);
        repeat (2) applyStimulus(4'b0000, 4'b0000, 1, 0, 0, 4);

        $display("[TB] directed: single shot and aborts");
        sso_i = 1'b1;
        applyStimulus(4'b0100, 4'b0000, 0, 0, 0, 4);
        applyStimulus(4'b0000, 4'b0000, 0, 1, 0, 4);
        sso_i = 1'b0;
        bus_idle_i = 1'b0;
        applyStimulus(4'b0010, 4'b0000, 0, 0, 0, 0);
        applyStimulus(4'b0000, 4'b0010, 0, 0, 0, 3);
        bus_idle_i = 1'b1;
        applyStimulus(4'b0001, 4'b0000, 0, 0, 0, 4);
        applyStimulus(4'b0000, 4'b0001, 0, 0, 0, 1);
        applyStimulus(4'b0000, 4'b0000, 1, 0, 0, 3);
        applyStimulus(4'b0001, 4'b0000, 0, 0, 0, 4);
        applyStimulus(4'b0000, 4'b0001, 0, 0, 0, 1);
        applyStimulus(4'b0000, 4'b0000, 0, 1, 0, 3);

        $display("[TB] directed: bus busy hold and reset in flight");
        bus_idle_i = 1'b0;
        applyStimulus(4'b0001, 4'b0000, 0, 0, 0, 20);
        bus_idle_i = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 0, 0, 0, 3);
        applyStimulus(4'b0000, 4'b0000, 1, 0, 0, 2);
        applyStimulus(4'b0110, 4'b0000, 0, 0, 0, 4);
        doReset("resetInWait");

        $display("[TB] random phase");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                int mb = $urandom_range(0, NMB-1);
                setId(mb, {bases[$urandom_range(0, 2)] ^ 11'($urandom_range(0, 3)), 18'($urandom)},
                      1'($urandom));
            end
            if ($urandom_range(0, 63) == 0) sso_i = ~sso_i;
            bus_idle_i = (n % 500 >= 470) ? 1'b0 : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NMB; i++) begin
                mb_req_i[i]   = ($urandom_range(0, 7) == 0);
                mb_abort_i[i] = ($urandom_range(0, 39) == 0);
            end
            case ($urandom_range(0, 11))
                0: begin tx_done_i = 1'b1; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0; end
                1: begin tx_done_i = 1'b0; tx_err_i = 1'b1; tx_arb_lost_i = 1'b0; end
                2: begin tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b1; end
                3: begin tx_done_i = 1'b1; tx_err_i = 1'b1; tx_arb_lost_i = 1'b1; end
                default: begin tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0; end
            endcase
            @(negedge clk);
            if (n == 1700) doReset("resetMidRun");
        end
        mb_req_i = '0; mb_abort_i = '0;
        tx_done_i = 1'b0; tx_err_i = 1'b0; tx_arb_lost_i = 1'b0;
        repeat (4) @(negedge clk);

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drainQueue got %0d outstanding want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
